// File: rtl/ifetch_pkg.sv
// Shared types for the instruction-fetch front end: FSM states, PC step
// and the entry layout stored in the fetch queue.
package ifetch_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    FLUSH
  } state_t;

  localparam int PC_INC = 4;

  // Default-width view of one queue entry; the queue packs {pc, inst} in this order.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/ifetch_queue_fifo.sv
// Generic synchronous FIFO with registered head output, shaped for block RAM.
// A push into an effectively empty queue is forwarded straight to the head register.
module sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   clear,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       head,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr_reg;
  logic [PW-1:0]    wr_ptr_reg;
  logic [PW-1:0]    rd_ptr_next;
  logic [PW:0]      count_reg;
  logic [WIDTH-1:0] head_reg;

  assign rd_ptr_next = rd_ptr_reg + PW'(pop);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
      head_reg   <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PW'(1);
      end
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_reg + (PW+1)'(push) - (PW+1)'(pop);
      // The slot being written is the next head only when nothing else is queued.
      head_reg   <= (push && (wr_ptr_reg == rd_ptr_next)) ? wdata : mem[rd_ptr_next];
      assert (!(push && !pop && (count_reg == (PW+1)'(DEPTH))));
    end
  end

  assign head  = head_reg;
  assign count = count_reg;

endmodule

// File: rtl/ifetch_queue.sv
// Fetch PC owner and instruction-memory handshake; fetched words are queued
// with their PCs and streamed to decode. A redirect flushes queue and fetch.
module ifetch_queue
  import ifetch_pkg::*;
#(
  parameter int                DEPTH    = 4,
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     mem_req,
  output logic [ADDR_W-1:0]        mem_addr,
  input  logic                     mem_ack,
  input  logic [DATA_W-1:0]        mem_rdata,
  output logic                     inst_valid,
  output logic [DATA_W-1:0]        inst,
  output logic [ADDR_W-1:0]        inst_pc,
  input  logic                     inst_ready,
  input  logic                     redirect,
  input  logic [ADDR_W-1:0]        redirect_pc,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int CW = $clog2(DEPTH) + 1;

  state_t              state_reg, state_next;
  logic [ADDR_W-1:0]   fetch_pc_reg, fetch_pc_next;
  logic [ADDR_W-1:0]   flush_addr_reg, flush_addr_next;
  logic [ADDR_W-1:0]   redirect_aligned;
  logic                push, pop;
  logic [CW-1:0]       count;
  logic [CW-1:0]       count_after_pop;
  logic [ADDR_W+DATA_W-1:0] head;

  assign redirect_aligned = redirect_pc & ~ADDR_W'(3);
  assign inst_valid       = (count != '0);
  assign pop              = inst_valid && inst_ready && !redirect;
  assign count_after_pop  = count - CW'(pop);

  always_comb begin
    state_next      = state_reg;
    fetch_pc_next   = fetch_pc_reg;
    flush_addr_next = flush_addr_reg;
    push            = 1'b0;
    mem_req         = 1'b0;
    mem_addr        = '0;
    case (state_reg)
      IDLE: begin
        if (redirect) begin
          fetch_pc_next = redirect_aligned;
        end else if (count_after_pop < CW'(DEPTH)) begin
          state_next = BUSY;
        end
      end
      BUSY: begin
        mem_req  = 1'b1;
        mem_addr = fetch_pc_reg;
        if (redirect) begin
          fetch_pc_next = redirect_aligned;
          if (mem_ack) begin
            state_next = IDLE;
          end else begin
            // Outstanding request must finish at its original address.
            state_next      = FLUSH;
            flush_addr_next = fetch_pc_reg;
          end
        end else if (mem_ack) begin
          push          = 1'b1;
          fetch_pc_next = fetch_pc_reg + ADDR_W'(PC_INC);
          if ((count_after_pop + CW'(1)) >= CW'(DEPTH)) begin
            state_next = IDLE;
          end
        end
      end
      FLUSH: begin
        mem_req  = 1'b1;
        mem_addr = flush_addr_reg;
        if (redirect) begin
          fetch_pc_next = redirect_aligned;
        end
        if (mem_ack) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      fetch_pc_reg   <= RESET_PC;
      flush_addr_reg <= '0;
    end else begin
      state_reg      <= state_next;
      fetch_pc_reg   <= fetch_pc_next;
      flush_addr_reg <= flush_addr_next;
    end
  end

  sync_fifo #(
    .WIDTH (ADDR_W + DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .clear (redirect),
    .wdata ({fetch_pc_reg, mem_rdata}),
    .head  (head),
    .count (count)
  );

  assign inst_pc   = head[ADDR_W+DATA_W-1 -: ADDR_W];
  assign inst      = head[DATA_W-1:0];
  assign occupancy = count;

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue: a small instruction-memory model with
// programmable ack latency, and hand-computed expectations per scenario.
module tb_ifetch_queue;
  import ifetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_req, mem_ack;
  logic [31:0] mem_addr, mem_rdata;
  logic        inst_valid, inst_ready;
  logic [31:0] inst, inst_pc;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [2:0]  occupancy;

  int tests = 0;
  int fails = 0;
  int latency = 0;
  int lat_cnt;
  fetch_entry_t exp_e;

  always #5 clk = ~clk;

  ifetch_queue #(
    .DEPTH    (4),
    .ADDR_W   (32),
    .DATA_W   (32),
    .RESET_PC (32'h0)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .inst_valid  (inst_valid),
    .inst        (inst),
    .inst_pc     (inst_pc),
    .inst_ready  (inst_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .occupancy   (occupancy)
  );

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return {~a[15:0], a[15:0]};
  endfunction

  // Memory model: acks after `latency` extra cycles of a held request.
  always_ff @(posedge clk) begin
    if (rst || !mem_req || mem_ack) lat_cnt <= 0;
    else                            lat_cnt <= lat_cnt + 1;
  end

  always_comb begin
    mem_ack   = mem_req && (lat_cnt >= latency);
    mem_rdata = mem_ack ? word_at(mem_addr) : 32'h0;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic wait_req(input logic level, input string tag);
    int g = 0;
    while (mem_req !== level && g < 50) begin
      tick();
      g++;
    end
    chk(tag, mem_req, level);
  endtask

  task automatic chk_head(input string tag, input logic [31:0] pc);
    exp_e = '{pc: pc, inst: word_at(pc)};
    chk(tag, {inst_pc, inst}, exp_e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    logic [31:0] exp_pc;
    rst = 1'b1; inst_ready = 1'b1; redirect = 1'b0; redirect_pc = 32'h0;

    // 1: reset state, then zero-wait streaming at one instruction per cycle
    latency = 0;
    do_reset();
    chk("rst_req", mem_req, 0);
    chk("rst_valid", inst_valid, 0);
    chk("rst_occ", occupancy, 0);
    chk("rst_inst", inst, 0);
    chk("rst_pc", inst_pc, 0);
    chk("rst_addr", mem_addr, 0);
    tick();
    chk("s1_req", mem_req, 1);
    chk("s1_addr", mem_addr, 32'h0);
    chk("s1_valid", inst_valid, 0);
    for (int k = 2; k < 8; k++) begin
      tick();
      chk("s1_stream_valid", inst_valid, 1);
      chk_head("s1_stream_head", 32'(4 * (k - 2)));
      chk("s1_stream_addr", mem_addr, 32'(4 * (k - 1)));
    end

    // 2: back-pressure fills the queue, then drain resumes at 0x10
    inst_ready = 1'b0;
    do_reset();
    repeat (5) tick();
    chk("s2_full_req", mem_req, 0);
    chk("s2_full_occ", occupancy, 4);
    chk_head("s2_full_head", 32'h0);
    repeat (2) tick();
    chk("s2_hold_req", mem_req, 0);
    chk("s2_hold_occ", occupancy, 4);
    inst_ready = 1'b1;
    #1;
    exp_pc = 32'h0;
    for (int i = 0; i < 10; i++) begin
      chk("s2_drain_valid", inst_valid, 1);
      chk_head("s2_drain_head", exp_pc);
      if (i == 1) begin
        chk("s2_resume_req", mem_req, 1);
        chk("s2_resume_addr", mem_addr, 32'h10);
      end
      exp_pc += 4;
      tick();
    end

    // 3: redirect while a slow fetch at 0x8 is outstanding
    latency = 3; inst_ready = 1'b0;
    do_reset();
    g = 0;
    while (!(mem_req && mem_addr == 32'h8) && g < 60) begin
      tick();
      g++;
    end
    chk("s3_at8", mem_addr, 32'h8);
    chk("s3_occ_before", occupancy, 2);
    redirect = 1'b1; redirect_pc = 32'h100;
    tick();
    redirect = 1'b0;
    #1;
    chk("s3_flush_req", mem_req, 1);
    chk("s3_flush_occ", occupancy, 0);
    chk("s3_flush_valid", inst_valid, 0);
    g = 0;
    while (!mem_ack && g < 20) begin
      chk("s3_hold_addr", mem_addr, 32'h8);
      tick();
      g++;
    end
    chk("s3_flush_ack", mem_ack, 1);
    chk("s3_ack_addr", mem_addr, 32'h8);
    tick();
    chk("s3_idle_req", mem_req, 0);
    chk("s3_dropped_occ", occupancy, 0);
    tick();
    chk("s3_new_req", mem_req, 1);
    chk("s3_new_addr", mem_addr, 32'h100);
    g = 0;
    while (!mem_ack && g < 20) begin
      chk("s3_empty_valid", inst_valid, 0);
      tick();
      g++;
    end
    chk("s3_new_ack", mem_ack, 1);
    tick();
    chk("s3_arrive_valid", inst_valid, 1);
    chk_head("s3_arrive_head", 32'h100);
    chk("s3_arrive_occ", occupancy, 1);

    // 4: redirect coincident with ack, two entries queued
    latency = 0; inst_ready = 1'b0;
    do_reset();
    repeat (3) tick();
    chk("s4_occ2", occupancy, 2);
    chk("s4_addr8", mem_addr, 32'h8);
    redirect = 1'b1; redirect_pc = 32'h40;
    tick();
    redirect = 1'b0;
    #1;
    chk("s4_clr_occ", occupancy, 0);
    chk("s4_clr_valid", inst_valid, 0);
    chk("s4_clr_req", mem_req, 0);
    tick();
    chk("s4_new_req", mem_req, 1);
    chk("s4_new_addr", mem_addr, 32'h40);
    tick();
    chk("s4_head_valid", inst_valid, 1);
    chk_head("s4_head", 32'h40);
    chk("s4_occ1", occupancy, 1);

    // 5: repeated redirects during FLUSH, last one wins and is aligned
    latency = 3; inst_ready = 1'b1;
    do_reset();
    tick();
    chk("s5_busy_req", mem_req, 1);
    redirect = 1'b1; redirect_pc = 32'h200;
    tick();
    chk("s5_flush_req", mem_req, 1);
    chk("s5_flush_addr", mem_addr, 32'h0);
    redirect_pc = 32'h250;
    tick();
    redirect_pc = 32'h303;
    tick();
    redirect = 1'b0;
    #1;
    chk("s5_stale_addr", mem_addr, 32'h0);
    wait_req(1'b0, "s5_drop");
    wait_req(1'b1, "s5_restart");
    chk("s5_resume_addr", mem_addr, 32'h300);

    // 6: reset in the middle of BUSY with a non-empty queue
    latency = 0; inst_ready = 1'b0;
    do_reset();
    repeat (3) tick();
    chk("s6_occ_before", occupancy, 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("s6_req", mem_req, 0);
    chk("s6_valid", inst_valid, 0);
    chk("s6_occ", occupancy, 0);
    tick();
    chk("s6_restart_req", mem_req, 1);
    chk("s6_restart_addr", mem_addr, 32'h0);
    tick();
    chk_head("s6_restart_head", 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
